// File: rtl/modpoly_mem_arb.sv
// Round-robin access controller for the 13x2048 SNTRUP757 polynomial RAM, with registered read return.
// Define MODPOLY_CLR_EN to build in the clear engine that zeroes addresses 0..POLY_LEN-1.
module modpoly_mem_arb #(
    parameter int unsigned RAM_WIDTH     = 13,
    parameter int unsigned RAM_ADDR_BITS = 11,
    parameter int unsigned POLY_LEN      = 757
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [RAM_ADDR_BITS-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0]     a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [RAM_WIDTH-1:0]     a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [RAM_ADDR_BITS-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0]     b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [RAM_WIDTH-1:0]     b_rdata,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_waddr,
    output logic [RAM_WIDTH-1:0]     mem_wdata,
    output logic [RAM_ADDR_BITS-1:0] mem_raddr,
    input  logic [RAM_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned AW = RAM_ADDR_BITS;
    localparam int unsigned DW = RAM_WIDTH;
    localparam logic [AW-1:0] CLR_LAST = AW'(POLY_LEN - 1);

    logic last_b;
    logic in_clear;
    logic clr_go;
    logic a_sel;
    logic b_sel;

`ifdef MODPOLY_CLR_EN
    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;

    assign in_clear = (state == S_CLEAR);
    assign clr_go   = (state == S_IDLE) && clr_start;

    // Clear engine: one zero write per cycle, done pulse on the cycle arbitration resumes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        state    <= S_CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state    <= S_IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_clr;

    assign in_clear   = 1'b0;
    assign clr_go     = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign unused_clr = ^{clr_start, CLR_LAST};
`endif

    // Round-robin grant; a tie goes to whoever was not granted last
    always_comb begin
        a_sel = 1'b0;
        b_sel = 1'b0;
        if (!rst && !in_clear && !clr_go) begin
            if (a_req && b_req) begin
                a_sel = last_b;
                b_sel = !last_b;
            end else begin
                a_sel = a_req;
                b_sel = b_req;
            end
        end
    end

    assign a_gnt = a_sel;
    assign b_gnt = b_sel;

    // RAM port steering
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = a_addr;
        if (rst) begin
            mem_raddr = '0;
        end else if (in_clear) begin
`ifdef MODPOLY_CLR_EN
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
`endif
        end else if (a_sel) begin
            mem_raddr = a_addr;
            if (a_we) begin
                mem_we    = 1'b1;
                mem_waddr = a_addr;
                mem_wdata = a_wdata;
            end
        end else if (b_sel) begin
            mem_raddr = b_addr;
            if (b_we) begin
                mem_we    = 1'b1;
                mem_waddr = b_addr;
                mem_wdata = b_wdata;
            end
        end
    end

    // Arbitration history and registered read return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            if (a_sel) begin
                last_b <= 1'b0;
            end else if (b_sel) begin
                last_b <= 1'b1;
            end
            a_rvalid <= a_sel && !a_we;
            b_rvalid <= b_sel && !b_we;
            if (a_sel && !a_we) begin
                a_rdata <= DW'(mem_rdata);
            end
            if (b_sel && !b_we) begin
                b_rdata <= DW'(mem_rdata);
            end
        end
    end

    a_one_grant : assert property (@(posedge clk) disable iff (rst) !(a_gnt && b_gnt));
    a_no_grant_in_clear : assert property (@(posedge clk) disable iff (rst)
        !(clr_busy && (a_gnt || b_gnt)));

endmodule

// File: tb/tb_modpoly_mem_arb.sv
// Scoreboard bench for modpoly_mem_arb: directed accesses against a behavioural RAM, monitor checks read returns.
`timescale 1ns/1ps
module tb_modpoly_mem_arb;

    localparam int unsigned W  = 13;
    localparam int unsigned AW = 11;
    localparam int unsigned PL = 757;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    modpoly_mem_arb #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .POLY_LEN(PL)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    // Behavioural RAM with a bench-side preload port used only while the DUT is not writing
    logic [W-1:0]  ram [2**AW];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [W-1:0]  pre_data = '0;

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end
    assign mem_rdata = ram[mem_raddr];

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   log_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   gnt_busy = 0;
    bit   gnt_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read returns whenever an rvalid appears
    always @(negedge clk) begin : monitor
        exp_t ea;
        exp_t eb;
        #2;
        if (!rst) begin
            if (a_rvalid) begin
                if (qa.size() == 0) chk("a_rvalid_unexpected", 1, 0);
                else begin
                    ea = qa.pop_front();
                    chk("a_rdata", 32'(a_rdata), 32'(ea.data));
                    chk("a_rvalid_cycle", cyc, ea.cyc);
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chk("b_rvalid_unexpected", 1, 0);
                else begin
                    eb = qb.pop_front();
                    chk("b_rdata", 32'(b_rdata), 32'(eb.data));
                    chk("b_rvalid_cycle", cyc, eb.cyc);
                end
            end
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (clr_busy && (a_gnt || b_gnt)) gnt_busy++;
        end
    end

    task automatic drive(input bit p, input bit r, input bit we, input logic [AW-1:0] addr,
                         input logic [W-1:0] d);
        if (!p) begin
            a_req = r; a_we = we; a_addr = addr; a_wdata = d;
        end else begin
            b_req = r; b_we = we; b_addr = addr; b_wdata = d;
        end
    endtask

    // Called just after a negedge; returns at a negedge. For reads, data is the expected value.
    task automatic access(input bit p, input bit we, input logic [AW-1:0] addr,
                          input logic [W-1:0] data, input int max_wait, input bit keep,
                          output int waited);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        waited = 0;
        drive(p, 1'b1, we, addr, we ? data : W'(0));
        while (!ok && waited < max_wait) begin
            #1;
            if ((p ? b_gnt : a_gnt) === 1'b1) begin
                ok = 1'b1;
                gnt_done = clr_done;
                log_q.push_back(p);
                if (!we) begin
                    e.data = data;
                    e.cyc  = cyc + 1;
                    if (p) qb.push_back(e);
                    else qa.push_back(e);
                end
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        if (!keep || !ok) drive(p, 1'b0, 1'b0, addr, W'(0));
        if (!ok) chk(p ? "b_grant_timeout" : "a_grant_timeout", 0, 1);
    endtask

    task automatic stream(input bit p, input logic [AW-1:0] abase, input logic [W-1:0] dbase,
                          input int n);
        int w;
        for (int i = 0; i < n; i++)
            access(p, 1'b0, abase + AW'(i), dbase + W'(i), 20, (i < n - 1), w);
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [W-1:0] d);
        pre_we = 1'b1; pre_addr = addr; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_gnt"}, 32'(a_gnt), 0);
        chk({tag, "_b_gnt"}, 32'(b_gnt), 0);
        chk({tag, "_a_rvalid"}, 32'(a_rvalid), 0);
        chk({tag, "_b_rvalid"}, 32'(b_rvalid), 0);
        chk({tag, "_a_rdata"}, 32'(a_rdata), 0);
        chk({tag, "_b_rdata"}, 32'(b_rdata), 0);
        chk({tag, "_clr_busy"}, 32'(clr_busy), 0);
        chk({tag, "_clr_done"}, 32'(clr_done), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_waddr"}, 32'(mem_waddr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_mem_raddr"}, 32'(mem_raddr), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        logic [AW-1:0] addrs [7];
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5); a_wdata = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = AW'(9); b_wdata = W'(13'h0123);
        clr_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        @(negedge clk);

        // A write then read of addr 5, zero-wait grants
        access(1'b0, 1'b1, AW'(5), W'(13'h1ABC), 5, 1'b0, w);
        chk("t1_write_wait", w, 0);
        access(1'b0, 1'b0, AW'(5), W'(13'h1ABC), 5, 1'b0, w);
        chk("t1_read_wait", w, 0);

        // B writes top address, A reads it the very next cycle
        access(1'b1, 1'b1, AW'(2047), W'(13'h0FFF), 5, 1'b0, w);
        chk("t3_b_write_wait", w, 0);
        access(1'b0, 1'b0, AW'(2047), W'(13'h0FFF), 5, 1'b0, w);
        chk("t3_a_raw_wait", w, 0);

        // Contention: A reads 0..3, B reads 100..103, must alternate starting with A
        for (int i = 0; i < 4; i++) begin
            preload(AW'(i), W'(13'h0200) + W'(i));
            preload(AW'(100 + i), W'(13'h0300) + W'(i));
        end
        access(1'b1, 1'b0, AW'(100), W'(13'h0300), 5, 1'b0, w);
        log_q.delete();
        fork
            stream(1'b0, AW'(0), W'(13'h0200), 4);
            stream(1'b1, AW'(100), W'(13'h0300), 4);
        join
        chk("t2_grant_count", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk($sformatf("t2_grant_order_%0d", i), 32'(log_q[i]), 32'(i % 2));

`ifdef MODPOLY_CLR_EN
        // Clear with an A request held and a repeated clr_start mid-clear
        access(1'b0, 1'b1, AW'(0), W'(13'h1111), 5, 1'b0, w);
        access(1'b0, 1'b1, AW'(756), W'(13'h1111), 5, 1'b0, w);
        access(1'b0, 1'b1, AW'(757), W'(13'h1111), 5, 1'b0, w);
        busy_cnt = 0; done_cnt = 0; gnt_busy = 0;
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        fork
            begin
                repeat (100) @(negedge clk);
                clr_start = 1'b1;
                @(negedge clk);
                clr_start = 1'b0;
            end
            access(1'b0, 1'b0, AW'(0), W'(0), 800, 1'b0, w);
        join
        chk("t4_held_req_wait", w, 757);
        chk("t4_gnt_with_done", 32'(gnt_done), 1);
        repeat (3) @(negedge clk);
        chk("t4_busy_cycles", busy_cnt, 757);
        chk("t4_done_pulses", done_cnt, 1);
        chk("t4_gnt_while_busy", gnt_busy, 0);
        access(1'b0, 1'b0, AW'(756), W'(0), 5, 1'b0, w);
        access(1'b0, 1'b0, AW'(757), W'(13'h1111), 5, 1'b0, w);

        // clr_start coincident with a B request: no grant that cycle
        access(1'b0, 1'b1, AW'(10), W'(13'h0AAA), 5, 1'b0, w);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        drive(1'b1, 1'b1, 1'b0, AW'(10), '0);
        #1;
        chk("t5_no_bgnt_on_start", 32'(b_gnt), 0);
        @(negedge clk);
        clr_start = 1'b0;
        access(1'b1, 1'b0, AW'(10), W'(0), 800, 1'b0, w);
        chk("t5_b_wait", w, 757);
        repeat (3) @(negedge clk);
        chk("t5_busy_cycles", busy_cnt, 757);
        chk("t5_done_pulses", done_cnt, 1);

        // Reset asserted while the clear is writing address 300
        for (int i = 0; i < int'(PL); i++) preload(AW'(i), W'(13'h1000) | W'(i));
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midclr_rst");
        chk("t6_busy_before_rst", busy_cnt, 300);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_idle_after_rst", 32'(clr_busy), 0);
        addrs[0] = AW'(0);   addrs[1] = AW'(150); addrs[2] = AW'(299); addrs[3] = AW'(300);
        addrs[4] = AW'(301); addrs[5] = AW'(500); addrs[6] = AW'(756);
        for (int i = 0; i < 7; i++)
            access(1'b1, 1'b0, addrs[i], (addrs[i] < AW'(300)) ? W'(0) : (W'(13'h1000) | W'(addrs[i])),
                   5, 1'b0, w);
`else
        // Without the clear engine clr_start has no effect
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        access(1'b0, 1'b0, AW'(5), W'(13'h1ABC), 5, 1'b0, w);
        clr_start = 1'b0;
        chk("noclr_grant_wait", w, 0);
        repeat (5) @(negedge clk);
        chk("noclr_busy", busy_cnt, 0);
        chk("noclr_done", done_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        chk("a_pending_reads", qa.size(), 0);
        chk("b_pending_reads", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
